// File: rtl/johnson_pkg.sv
// Shared types and helpers for the Johnson counter sequencing controller.
//   state_t     : controller state encoding (IDLE / RUN / PAUSE)
//   phase_width : bit width needed to index the 2*width-long Johnson sequence
package johnson_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 3;

    function automatic int unsigned phase_width(input int unsigned width);
        return $clog2(2 * width);
    endfunction

endpackage

// File: rtl/johnson_core.sv
// Johnson (twisted-ring) shift register datapath.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset, clears q
//   en    : advance one step this edge
//   dir   : 0 = forward {~q[0], q[W-1:1]}, 1 = reverse {q[W-2:0], ~q[W-1]}
//   clr   : synchronous clear to all-zeros, wins over en
//   q     : register value
module johnson_core #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            if (dir) begin
                q <= {q[WIDTH-2:0], ~q[WIDTH-1]};
            end else begin
                q <= {~q[0], q[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Commanded sequencing controller for a Johnson counter.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   start  : launch a run (IDLE only); len and dir are sampled with it
//   len    : number of advances, 0 = free-run until stop
//   dir    : 0 = forward, 1 = reverse
//   hold   : pause request while running
//   stop   : abort the run, return to IDLE
//   q      : Johnson register value
//   phase  : forward-order index of q (combinational)
//   busy   : high in RUN or PAUSE
//   paused : high in PAUSE
//   done   : one-cycle pulse when a finite run completes
//   wrap   : one-cycle pulse when an advance lands on all-zeros
module johnson_seq_ctrl
    import johnson_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [CNT_W-1:0]                len,
    input  logic                            dir,
    input  logic                            hold,
    input  logic                            stop,
    output logic [WIDTH-1:0]                q,
    output logic [phase_width(WIDTH)-1:0]   phase,
    output logic                            busy,
    output logic                            paused,
    output logic                            done,
    output logic                            wrap
);

    localparam int unsigned PH_W = phase_width(WIDTH);

    // The only states one advance away from all-zeros.
    localparam logic [WIDTH-1:0] FWD_PRE_ZERO = WIDTH'(1);
    localparam logic [WIDTH-1:0] REV_PRE_ZERO = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] remaining, remaining_nxt;
    logic             dir_r, dir_nxt;
    logic             done_nxt, wrap_nxt;
    logic             core_en, core_clr;

    johnson_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .en    (core_en),
        .dir   (dir_r),
        .clr   (core_clr),
        .q     (q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            remaining <= '0;
            dir_r     <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            dir_r     <= dir_nxt;
            done      <= done_nxt;
            wrap      <= wrap_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        dir_nxt       = dir_r;
        done_nxt      = 1'b0;
        wrap_nxt      = 1'b0;
        core_en       = 1'b0;
        core_clr      = 1'b0;

        case (state)
            IDLE: begin
                if (start && !stop) begin
                    core_clr      = 1'b1;
                    remaining_nxt = len;
                    dir_nxt       = dir;
                    state_nxt     = RUN;
                end
            end
            RUN, PAUSE: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (hold) begin
                    state_nxt = PAUSE;
                end else begin
                    // Advance; a paused run resumes on the same edge hold drops.
                    core_en   = 1'b1;
                    state_nxt = RUN;
                    wrap_nxt  = dir_r ? (q == REV_PRE_ZERO) : (q == FWD_PRE_ZERO);
                    // remaining == 0 marks a free-run and is never decremented.
                    if (remaining != '0) begin
                        remaining_nxt = remaining - CNT_ONE;
                        if (remaining == CNT_ONE) begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy   = (state != IDLE);
    assign paused = (state == PAUSE);

    // First half of the sequence fills ones from the MSB (phase = ones count);
    // second half drains them from the MSB (phase = 2*WIDTH - ones count).
    logic [PH_W-1:0] ones;

    always_comb begin
        ones = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            ones = ones + PH_W'(q[i]);
        end
        if (q[WIDTH-1] || (q == '0)) begin
            phase = ones;
        end else begin
            phase = PH_W'(2 * WIDTH) - ones;
        end
    end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
module tb_johnson_seq_ctrl;

    localparam int W = 3;
    localparam int N = 2 * W;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] len   = 8'd0;
    logic       dir   = 1'b0;
    logic       hold  = 1'b0;
    logic       stop  = 1'b0;
    logic [2:0] q;
    logic [2:0] phase;
    logic       busy, paused, done, wrap;

    int vectors = 0;
    int fails   = 0;

    johnson_seq_ctrl #(
        .WIDTH (3),
        .CNT_W (8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .len    (len),
        .dir    (dir),
        .hold   (hold),
        .stop   (stop),
        .q      (q),
        .phase  (phase),
        .busy   (busy),
        .paused (paused),
        .done   (done),
        .wrap   (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Johnson word for a sequence position: the first W positions fill ones
    // from the MSB, the rest clear them from the MSB.
    function automatic logic [2:0] q_of(input int p);
        logic [2:0] r;
        r = '0;
        for (int b = 0; b < W; b++) begin
            if (p <= W) r[W-1-b] = (b < p);
            else        r[W-1-b] = (b >= p - W);
        end
        return r;
    endfunction

    // Behavioural model: position in the ring, run/pause flags, countdown.
    int   m_ph    = 0;
    int   m_rem   = 0;
    bit   m_run   = 0;
    bit   m_pause = 0;
    bit   m_dir   = 0;
    bit   m_done  = 0;
    bit   m_wrap  = 0;

    always @(posedge clk or negedge reset) begin : model
        int nph;
        if (!reset) begin
            m_ph <= 0; m_rem <= 0; m_run <= 0; m_pause <= 0;
            m_dir <= 0; m_done <= 0; m_wrap <= 0;
        end else begin
            m_done <= 0;
            m_wrap <= 0;
            if (!m_run && !m_pause) begin
                if (start && !stop) begin
                    m_ph <= 0; m_rem <= int'(len); m_dir <= dir; m_run <= 1;
                end
            end else if (stop) begin
                m_run <= 0; m_pause <= 0;
            end else if (hold) begin
                m_run <= 0; m_pause <= 1;
            end else begin
                nph = m_dir ? (m_ph + N - 1) % N : (m_ph + 1) % N;
                m_ph    <= nph;
                m_wrap  <= (nph == 0);
                m_run   <= 1;
                m_pause <= 0;
                if (m_rem != 0) begin
                    m_rem <= m_rem - 1;
                    if (m_rem == 1) begin
                        m_run  <= 0;
                        m_done <= 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("q",      {5'd0, q},       {5'd0, q_of(m_ph)});
        chk("phase",  {5'd0, phase},   8'(m_ph));
        chk("busy",   {7'd0, busy},    {7'd0, m_run | m_pause});
        chk("paused", {7'd0, paused},  {7'd0, m_pause});
        chk("done",   {7'd0, done},    {7'd0, m_done});
        chk("wrap",   {7'd0, wrap},    {7'd0, m_wrap});
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [2:0] exp_a [6] = '{3'b100, 3'b110, 3'b111, 3'b011, 3'b001, 3'b000};
    logic [2:0] exp_c [4] = '{3'b111, 3'b011, 3'b001, 3'b000};

    initial begin
        int busy_cnt;
        int wraps;
        int dones;

        #2 reset = 1'b0;
        #6;
        chk("rst_q",    {5'd0, q},      8'h00);
        chk("rst_busy", {7'd0, busy},   8'h00);
        chk("rst_done", {7'd0, done},   8'h00);
        chk("rst_wrap", {7'd0, wrap},   8'h00);
        tick;
        reset = 1'b1;
        tick;

        // Finite forward run over the full ring.
        start = 1; len = 8'd6; dir = 0;
        tick;
        start = 0;
        chk("a_q0",    {5'd0, q},    8'h00);
        chk("a_busy0", {7'd0, busy}, 8'h01);
        busy_cnt = 1;
        for (int i = 0; i < 6; i++) begin
            tick;
            chk("a_q",     {5'd0, q},     {5'd0, exp_a[i]});
            chk("a_phase", {5'd0, phase}, 8'((i + 1) % 6));
            if (busy) busy_cnt++;
        end
        chk("a_done",  {7'd0, done}, 8'h01);
        chk("a_wrap",  {7'd0, wrap}, 8'h01);
        chk("a_busyn", 8'(busy_cnt), 8'd6);

        // Reverse run of 2, launched on the done cycle.
        start = 1; len = 8'd2; dir = 1;
        tick;
        start = 0; dir = 0;
        chk("b_q0", {5'd0, q}, 8'h00);
        tick;
        chk("b_q1",  {5'd0, q},     8'h01);
        chk("b_ph1", {5'd0, phase}, 8'd5);
        tick;
        chk("b_q2",   {5'd0, q},     8'h03);
        chk("b_ph2",  {5'd0, phase}, 8'd4);
        chk("b_done", {7'd0, done},  8'h01);
        chk("b_wrap", {7'd0, wrap},  8'h00);

        // Forward run of 6 with three hold cycles at q=110.
        start = 1; len = 8'd6;
        tick;
        start = 0;
        tick;
        tick;
        chk("c_q110", {5'd0, q}, 8'h06);
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("c_paused", {7'd0, paused}, 8'h01);
            chk("c_qhold",  {5'd0, q},      8'h06);
            chk("c_busy",   {7'd0, busy},   8'h01);
        end
        hold = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("c_q",    {5'd0, q},    {5'd0, exp_c[i]});
            chk("c_done", {7'd0, done}, (i == 3) ? 8'h01 : 8'h00);
        end

        // Free-run: 13 advances then stop.
        start = 1; len = 8'd0;
        tick;
        start = 0;
        wraps = 0;
        dones = 0;
        for (int i = 0; i < 13; i++) begin
            tick;
            if (wrap) wraps++;
            if (done) dones++;
        end
        chk("d_q",     {5'd0, q}, 8'h04);
        chk("d_wraps", 8'(wraps), 8'd2);
        chk("d_dones", 8'(dones), 8'd0);
        stop = 1;
        tick;
        stop = 0;
        chk("d_busy", {7'd0, busy}, 8'h00);
        chk("d_qs",   {5'd0, q},    8'h04);
        chk("d_done", {7'd0, done}, 8'h00);
        tick;
        chk("d_qs2",  {5'd0, q},    8'h04);

        // start during RUN is ignored.
        start = 1; len = 8'd3;
        tick;
        len = 8'd5;
        tick;
        chk("e_q1", {5'd0, q}, 8'h04);
        tick;
        start = 0;
        chk("e_q2",   {5'd0, q},    8'h06);
        chk("e_busy", {7'd0, busy}, 8'h01);
        tick;
        chk("e_q3",   {5'd0, q},    8'h07);
        chk("e_done", {7'd0, done}, 8'h01);

        // start together with stop in IDLE.
        start = 1; stop = 1; len = 8'd4;
        tick;
        start = 0; stop = 0;
        chk("f_busy", {7'd0, busy}, 8'h00);
        chk("f_q",    {5'd0, q},    8'h07);
        tick;
        chk("f_busy2", {7'd0, busy}, 8'h00);

        // Asynchronous reset mid-run at q=110.
        start = 1; len = 8'd6;
        tick;
        start = 0;
        tick;
        tick;
        chk("g_q110", {5'd0, q}, 8'h06);
        #2 reset = 1'b0;
        #1;
        chk("g_q",      {5'd0, q},      8'h00);
        chk("g_busy",   {7'd0, busy},   8'h00);
        chk("g_done",   {7'd0, done},   8'h00);
        chk("g_wrap",   {7'd0, wrap},   8'h00);
        chk("g_paused", {7'd0, paused}, 8'h00);
        tick;
        reset = 1'b1;
        tick;
        tick;
        chk("g_idle", {7'd0, busy}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
